instruction_fetch_unit: RTL and testbench

Core-side fetch stage directly upstream of the instruction cache controller. Generates sequential word-aligned fetch addresses, drives the cache's cpu_addr/cpu_req handshake with at most one request in flight, buffers returned instructions in a small FIFO, and presents them to decode with a valid/ready handshake. Branch/exception redirects flush the buffer and squash any in-flight response.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_fifo.sv | 56 +++++
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
// Fetch states, buffer entry layout and address helpers.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    KILL
  } ifu_state_e;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fifo_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Instruction buffer between the cache port and decode.
// Synchronous FIFO with flush; flush beats push and pop.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          push,
  input  fifo_entry_t   push_entry,
  input  logic          pop,
  input  logic          flush,
  output fifo_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush
                && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one-outstanding cache requests into a decode FIFO.
// IFU_PERF_COUNTERS_EN adds fetched/squashed response counters.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        fetch_en,
  output logic [31:0] cpu_addr,
  output logic        cpu_req,
  input  logic [31:0] cpu_data,
  input  logic        cpu_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        resp;
  logic        push;
  logic        pop;
  logic        post_room;

  fifo_entry_t   head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  assign cpu_req  = (state_q == REQ)
                 || (state_q == KILL);
  assign cpu_addr = addr_q;
  assign resp     = cpu_req && cpu_ready;
  assign tgt      = word_align(redirect_pc);
  assign pc_inc   = pc_q + 32'(WORD_BYTES);
  assign push     = (state_q == REQ) && resp
                 && !redirect_valid;
  assign pop      = inst_ready && !empty;

  // Occupancy once this cycle's push and pop land
  assign post_room =
    (count + CW'(1) - CW'(pop)) < CW'(FIFO_DEPTH);

  assign inst_valid = !empty;
  assign inst_data  = empty ? '0 : head.data;
  assign inst_pc    = empty ? '0 : head.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (redirect_valid) pc_d = tgt;
    unique case (state_q)
      IDLE: begin
        if (fetch_en && (redirect_valid || !full)) begin
          state_d = REQ;
          addr_d  = pc_d;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          if (!resp) begin
            state_d = KILL;
          end else if (fetch_en) begin
            addr_d = pc_d;
          end else begin
            state_d = IDLE;
          end
        end else if (resp) begin
          pc_d = pc_inc;
          if (fetch_en && post_room) addr_d = pc_inc;
          else state_d = IDLE;
        end
      end
      KILL: begin
        // Stale response is dropped; restart at the latest target
        if (resp) begin
          if (fetch_en && (redirect_valid || !full)) begin
            state_d = REQ;
            addr_d  = pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .push      (push),
    .push_entry('{data: cpu_data, pc: addr_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef IFU_PERF_COUNTERS_EN
  logic squash;

  assign squash = resp
               && (redirect_valid || state_q == KILL);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(push);
      perf_squashed <= perf_squashed + 32'(squash);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable
// cache model and an expected-PC scoreboard on the decode side.
module tb_instruction_fetch_unit;

  localparam logic [31:0] KEY = 32'hC0DE_5A00;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        fetch_en;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic [31:0] cpu_data = '0;
  logic        cpu_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] cpu_addr2;
  logic        cpu_req2;
  logic [31:0] cpu_data2;
  logic        cpu_ready2;
  logic        inst_valid2;
  logic [31:0] inst_data2;
  logic [31:0] inst_pc2;
  logic        one;

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] pf, ps, pf2, ps2;
`endif

  assign one        = 1'b1;
  assign cpu_ready2 = 1'b1;
  assign cpu_data2  = cpu_addr2 ^ KEY;

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int mcnt = 0;
  int acc_cnt = 0;
  int a0;
  logic [31:0] acc_addr = '0;
  logic [31:0] q[$];
  logic [31:0] q2[$];

  instruction_fetch_unit u_dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .fetch_en      (fetch_en),
    .cpu_addr      (cpu_addr),
    .cpu_req       (cpu_req),
    .cpu_data      (cpu_data),
    .cpu_ready     (cpu_ready),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .perf_fetched  (pf),
    .perf_squashed (ps)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC(32'hFFFF_FFF8)
  ) u_wrap (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .fetch_en      (one),
    .cpu_addr      (cpu_addr2),
    .cpu_req       (cpu_req2),
    .cpu_data      (cpu_data2),
    .cpu_ready     (cpu_ready2),
    .inst_valid    (inst_valid2),
    .inst_data     (inst_data2),
    .inst_pc       (inst_pc2),
    .inst_ready    (one),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .perf_fetched  (pf2),
    .perf_squashed (ps2)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Cache model: ready arrives lat cycles after a request starts
  always begin
    @(posedge HCLK);
    #1;
    if (!cpu_req) begin
      mcnt = 0;
      cpu_ready = 1'b0;
    end else if (cpu_ready) begin
      mcnt = 1;
      cpu_ready = 1'b0;
    end else begin
      cpu_ready = (mcnt >= lat);
      mcnt++;
      if (cpu_ready) begin
        acc_cnt++;
        acc_addr = cpu_addr;
      end
    end
    cpu_data = cpu_addr ^ KEY;
  end

  always @(negedge HCLK) begin
    logic [31:0] e;
    if (!HRESET && inst_valid && inst_ready
        && !redirect_valid) begin
      n_vec++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL extra_pop: observed pc %h expected none",
               inst_pc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pop_pc", inst_pc, e);
        chk("pop_data", inst_data, e ^ KEY);
      end
    end
    if (!HRESET && inst_valid2 && q2.size() > 0) begin
      e = q2.pop_front();
      chk("wrap_pc", inst_pc2, e);
      chk("wrap_data", inst_data2, e ^ KEY);
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #2;
  endtask

  task automatic do_reset;
    HRESET = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  initial begin
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    q2.push_back(32'hFFFF_FFF8);
    q2.push_back(32'hFFFF_FFFC);
    q2.push_back(32'h0000_0000);
    q2.push_back(32'h0000_0004);
    tick();
    tick();
    chk("rst_req", 32'(cpu_req), 32'h0);
    chk("rst_addr", cpu_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr2", cpu_addr2, 32'hFFFF_FFF8);
`ifdef IFU_PERF_COUNTERS_EN
    chk("rst_pf", pf, 32'h0);
    chk("rst_pf2", pf2, 32'h0);
`endif

    // Sequential fetch, 1-cycle hits, decode always ready
    for (int i = 0; i < 8; i++) q.push_back(32'(4 * i));
    HRESET = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    tick();
    chk("t1_req", 32'(cpu_req), 32'h1);
    chk("t1_addr0", cpu_addr, 32'h0);
    tick();
    tick();
    chk("t1_req_held", 32'(cpu_req), 32'h1);
    chk("t1_addr1", cpu_addr, 32'h4);
    chk("t1_valid", 32'(inst_valid), 32'h1);
    for (int i = 0; i < 80 && q.size() > 0; i++) tick();
    chk("t1_drain", 32'(q.size()), 32'h0);
    fetch_en = 1'b0;
    inst_ready = 1'b0;

    // Backpressure: fill the buffer, then free one slot
    do_reset();
    fetch_en = 1'b1;
    a0 = acc_cnt;
    repeat (30) tick();
    chk("t2_reqs", 32'(acc_cnt - a0), 32'd4);
    chk("t2_req_low", 32'(cpu_req), 32'h0);
    chk("t2_valid", 32'(inst_valid), 32'h1);
    chk("t2_head", inst_pc, 32'h0);
    q.push_back(32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (15) tick();
    chk("t2_one_more", 32'(acc_cnt - a0), 32'd5);
    chk("t2_addr", acc_addr, 32'h10);
    chk("t2_idle", 32'(cpu_req), 32'h0);
    chk("t2_q", 32'(q.size()), 32'h0);

    // Redirect during a 5-cycle miss
    do_reset();
    lat = 5;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    q.push_back(32'h1000);
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1003;
    tick();
    redirect_valid = 1'b0;
    chk("t3_hold_req", 32'(cpu_req), 32'h1);
    chk("t3_hold_addr", cpu_addr, 32'h0);
    for (int i = 0; i < 20 && !cpu_ready; i++) tick();
    chk("t3_ready_addr", cpu_addr, 32'h0);
    tick();
    chk("t3_new_addr", cpu_addr, 32'h1000);
    chk("t3_new_req", 32'(cpu_req), 32'h1);
    chk("t3_empty", 32'(inst_valid), 32'h0);
    fetch_en = 1'b0;
    repeat (12) tick();
    chk("t3_q", 32'(q.size()), 32'h0);
    chk("t3_idle", 32'(cpu_req), 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
    chk("t3_pf", pf, 32'd1);
    chk("t3_ps", ps, 32'd1);
`endif

    // Redirect on the same cycle as a response
    do_reset();
    lat = 1;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    q.push_back(32'h2000);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    chk("t4_addr", cpu_addr, 32'h2000);
    chk("t4_req", 32'(cpu_req), 32'h1);
    chk("t4_empty", 32'(inst_valid), 32'h0);
    repeat (8) tick();
    chk("t4_q", 32'(q.size()), 32'h0);
    chk("t4_idle", 32'(cpu_req), 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
    chk("t4_pf", pf, 32'd1);
    chk("t4_ps", ps, 32'd1);
`endif

    // Asynchronous reset in the middle of a miss
    do_reset();
    lat = 1;
    fetch_en = 1'b1;
    repeat (6) tick();
    lat = 5;
    tick();
    chk("t6_pre_valid", 32'(inst_valid), 32'h1);
    chk("t6_pre_req", 32'(cpu_req), 32'h1);
    #1;
    HRESET = 1'b1;
    #1;
    chk("t6_req", 32'(cpu_req), 32'h0);
    chk("t6_valid", 32'(inst_valid), 32'h0);
    chk("t6_addr", cpu_addr, 32'h0);
    chk("t6_pc", inst_pc, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
    chk("t6_pf", pf, 32'h0);
    chk("t6_ps", ps, 32'h0);
`endif
    tick();
    HRESET = 1'b0;
    lat = 1;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    q.push_back(32'h0);
    q.push_back(32'h4);
    q.push_back(32'h8);
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("t6_restart", 32'(q.size()), 32'h0);
    fetch_en = 1'b0;
    inst_ready = 1'b0;

    chk("wrap_done", 32'(q2.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
